serial_rc_subtractor: RTL and testbench

SERIAL_RC_SUBTRACTOR -- requirements
Module: serial_rc_subtractor

---
 rtl/serial_rc_subtractor_pkg.sv | 13 +
 rtl/serial_rc_subtractor_if.sv | 33 +++
 rtl/byte_rc_subtractor.sv | 26 ++
 rtl/serial_rc_subtractor.sv | 104 ++++++++++
 tb/tb_serial_rc_subtractor.sv | 311 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/serial_rc_subtractor_pkg.sv
// Shared types and default sizing for the chunk-serial ripple-borrow subtractor.
package serial_rc_subtractor_pkg;

  localparam int DEFAULT_WIDTH = 32;
  localparam int DEFAULT_CHUNK = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/serial_rc_subtractor_if.sv
// Operand/result bus for serial_rc_subtractor.
// Handshake: a transfer happens on a rising edge where valid and ready are both 1; the
// producer holds payload stable while valid is 1, and ready never depends on valid.
interface serial_rc_subtractor_if
  import serial_rc_subtractor_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) ();

  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             bin;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] d;
  logic             bout;
  logic             zero;
  logic             neg;
  logic             ovf;

  modport master (
    output in_valid, a, b, bin, out_ready,
    input  in_ready, out_valid, d, bout, zero, neg, ovf
  );

  modport slave (
    input  in_valid, a, b, bin, out_ready,
    output in_ready, out_valid, d, bout, zero, neg, ovf
  );

endinterface

// File: rtl/byte_rc_subtractor.sv
// Combinational ripple-borrow subtract slice: diff = x - y - bin, bout = borrow out of MSB.
module byte_rc_subtractor
  import serial_rc_subtractor_pkg::*;
#(
  parameter int WIDTH = DEFAULT_CHUNK
) (
  input  logic [WIDTH-1:0] x,
  input  logic [WIDTH-1:0] y,
  input  logic             bin,
  output logic [WIDTH-1:0] diff,
  output logic             bout
);

  always_comb begin : ripple
    logic c;
    diff = '0;
    c    = bin;
    for (int i = 0; i < WIDTH; i++) begin
      diff[i] = x[i] ^ y[i] ^ c;
      // Borrow propagates when bits are equal, is generated when x=0, y=1.
      c = (~x[i] & y[i]) | (~(x[i] ^ y[i]) & c);
    end
    bout = c;
  end

endmodule

// File: rtl/serial_rc_subtractor.sv
// Chunk-serial subtractor: one CHUNK-bit slice reused LSB-first over WIDTH/CHUNK cycles.
module serial_rc_subtractor
  import serial_rc_subtractor_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH,
  parameter int CHUNK = DEFAULT_CHUNK
) (
  input  logic                   clk,
  input  logic                   rst_n,
  serial_rc_subtractor_if.slave  bus,
  output state_t                 dbg_state
);

  localparam int NCHUNK = WIDTH / CHUNK;
  localparam int KW     = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
  localparam logic [KW-1:0] LAST = KW'(NCHUNK - 1);

  state_t           state;
  logic [KW-1:0]    k;
  logic             borrow;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic [WIDTH-1:0] d_q;
  logic             bout_q;
  logic             zero_q;
  logic             neg_q;
  logic             ovf_q;

  logic [CHUNK-1:0] diff;
  logic             slice_bout;
  logic [WIDTH-1:0] d_next;

  // Operands shift right each cycle so the active chunk is always the low CHUNK bits.
  byte_rc_subtractor #(.WIDTH(CHUNK)) u_slice (
    .x    (a_q[CHUNK-1:0]),
    .y    (b_q[CHUNK-1:0]),
    .bin  (borrow),
    .diff (diff),
    .bout (slice_bout)
  );

  // Result fills from the top; after the last chunk every piece sits in its place.
  always_comb begin
    d_next = d_q >> CHUNK;
    d_next[WIDTH-1 -: CHUNK] = diff;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      k      <= '0;
      borrow <= 1'b0;
      a_q    <= '0;
      b_q    <= '0;
      d_q    <= '0;
      bout_q <= 1'b0;
      zero_q <= 1'b0;
      neg_q  <= 1'b0;
      ovf_q  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.in_valid) begin
            a_q    <= bus.a;
            b_q    <= bus.b;
            borrow <= bus.bin;
            k      <= '0;
            state  <= BUSY;
          end
        end
        BUSY: begin
          a_q    <= a_q >> CHUNK;
          b_q    <= b_q >> CHUNK;
          d_q    <= d_next;
          borrow <= slice_bout;
          k      <= k + 1'b1;
          if (k == LAST) begin
            // On the last chunk the low slice bits hold the operands' sign bits.
            state  <= DONE;
            k      <= '0;
            bout_q <= slice_bout;
            zero_q <= (d_next == '0);
            neg_q  <= d_next[WIDTH-1];
            ovf_q  <= (a_q[CHUNK-1] ^ b_q[CHUNK-1]) & (d_next[WIDTH-1] ^ a_q[CHUNK-1]);
          end
        end
        DONE: begin
          if (bus.out_ready) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.in_ready  = (state == IDLE);
  assign bus.out_valid = (state == DONE);
  assign bus.d         = d_q;
  assign bus.bout      = bout_q;
  assign bus.zero      = zero_q;
  assign bus.neg       = neg_q;
  assign bus.ovf       = ovf_q;
  assign dbg_state     = state;

endmodule

// File: tb/tb_serial_rc_subtractor.sv
// Bench for serial_rc_subtractor: arithmetic/timing model, per-cycle compare, directed and random ops.
module tb_serial_rc_subtractor;
  import serial_rc_subtractor_pkg::*;

  localparam int WIDTH = 32;
  localparam int CHUNK = 8;
  localparam int NCH   = WIDTH / CHUNK;
  localparam int RW    = WIDTH + 4;

  logic   clk;
  logic   rst_n;
  state_t dbg_state;

  serial_rc_subtractor_if #(.WIDTH(WIDTH)) bus ();

  serial_rc_subtractor #(.WIDTH(WIDTH), .CHUNK(CHUNK)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .bus       (bus),
    .dbg_state (dbg_state)
  );

  int n_checks = 0;
  int n_fail   = 0;
  int edge_n   = 0;

  logic [RW-1:0] exp_q[$];
  int            acc_q[$];
  bit            m_busy = 0;
  int            acc_edge = 0;
  logic [RW-1:0] dut_res;

  // clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) edge_n <= edge_n + 1;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic fail(input string name);
    n_checks++;
    n_fail++;
    $display("FAIL %s: timed out (t=%0t)", name, $time);
  endtask

  // reference model: wide unsigned and signed arithmetic
  function automatic logic [RW-1:0] model_sub(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                                              input logic bin);
    logic [WIDTH:0]   full;
    logic [WIDTH-1:0] d;
    longint           sd;
    longint           smax;
    longint           smin;
    logic             ovf;
    full = {1'b0, a} - {1'b0, b} - {{WIDTH{1'b0}}, bin};
    d    = full[WIDTH-1:0];
    sd   = longint'($signed(a)) - longint'($signed(b)) - longint'(bin);
    smax = (longint'(1) <<< (WIDTH - 1)) - 1;
    smin = -(longint'(1) <<< (WIDTH - 1));
    ovf  = (sd > smax) || (sd < smin);
    return {full[WIDTH], (d == '0), d[WIDTH-1], ovf, d};
  endfunction

  function automatic logic [RW-1:0] pack(input logic [WIDTH-1:0] d, input logic bout, input logic zero,
                                         input logic neg, input logic ovf);
    return {bout, zero, neg, ovf, d};
  endfunction

  // scoreboard / compare: expected protocol state and result every cycle
  always @(negedge clk) begin
    logic [RW-1:0] got;
    bit            was_idle;
    got = {bus.bout, bus.zero, bus.neg, bus.ovf, bus.d};
    if (!rst_n) begin
      check("reset_outputs", 64'(got), 64'(0));
      check("reset_out_valid", 64'(bus.out_valid), 64'(0));
      exp_q.delete();
      m_busy = 0;
    end else begin
      was_idle = !m_busy;
      if (!m_busy) begin
        check("idle_in_ready", 64'(bus.in_ready), 64'(1));
        check("idle_out_valid", 64'(bus.out_valid), 64'(0));
      end else if (edge_n < acc_edge + NCH) begin
        check("busy_in_ready", 64'(bus.in_ready), 64'(0));
        check("busy_out_valid", 64'(bus.out_valid), 64'(0));
      end else begin
        check("done_out_valid", 64'(bus.out_valid), 64'(1));
        check("done_in_ready", 64'(bus.in_ready), 64'(0));
        if (exp_q.size() > 0) check("result", 64'(got), 64'(exp_q[0]));
        if (bus.out_ready) begin
          dut_res = got;
          void'(exp_q.pop_front());
          m_busy = 0;
        end
      end
      if (was_idle && bus.in_valid) begin
        exp_q.push_back(model_sub(bus.a, bus.b, bus.bin));
        acc_q.push_back(edge_n + 1);
        acc_edge = edge_n + 1;
        m_busy   = 1;
      end
    end
  end

  // driver tasks: all called and returning at posedge + 1
  task automatic send(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b, input logic bin);
    bit ok;
    ok = 0;
    bus.a = a;
    bus.b = b;
    bus.bin = bin;
    bus.in_valid = 1'b1;
    for (int i = 0; i < 50; i++) begin
      if (bus.in_ready) ok = 1;
      @(posedge clk);
      #1;
      if (ok) break;
    end
    bus.in_valid = 1'b0;
    if (!ok) fail("send");
  endtask

  task automatic wait_valid(input bit junk, output bit ok);
    ok = 0;
    for (int i = 0; i < 50; i++) begin
      if (bus.out_valid) begin
        ok = 1;
        break;
      end
      if (junk) begin
        bus.a         = $urandom;
        bus.b         = $urandom;
        bus.bin       = 1'($urandom_range(0, 1));
        bus.in_valid  = 1'($urandom_range(0, 1));
        bus.out_ready = 1'($urandom_range(0, 1));
      end
      @(posedge clk);
      #1;
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
  endtask

  task automatic wait_result(input int hold, input bit junk);
    bit ok;
    wait_valid(junk, ok);
    if (!ok) begin
      fail("wait_result");
      return;
    end
    repeat (hold) begin
      @(posedge clk);
      #1;
    end
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1;
    bus.out_ready = 1'b0;
  endtask

  task automatic run_vec(input string name, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                         input logic bin, input logic [RW-1:0] exp, input int hold);
    check({name, "_model"}, 64'(model_sub(a, b, bin)), 64'(exp));
    dut_res = '1;
    send(a, b, bin);
    wait_result(hold, 0);
    check(name, 64'(dut_res), 64'(exp));
  endtask

  initial begin
    logic [RW-1:0]    snap;
    logic [WIDTH-1:0] ra;
    logic [WIDTH-1:0] rb;
    bit               ok;

    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    bus.a         = '0;
    bus.b         = '0;
    bus.bin       = 1'b0;
    rst_n         = 1'b1;
    #1 rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_state", 64'(dbg_state), 64'(IDLE));
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // directed vectors
    run_vec("sub_5_3",       32'h0000_0005, 32'h0000_0003, 1'b0, pack(32'h0000_0002, 0, 0, 0, 0), 0);
    run_vec("chunk_borrow",  32'h0000_0100, 32'h0000_0001, 1'b0, pack(32'h0000_00FF, 0, 0, 0, 0), 1);
    run_vec("wrap_neg",      32'h0000_0000, 32'h0000_0001, 1'b0, pack(32'hFFFF_FFFF, 1, 0, 1, 0), 0);
    run_vec("ovf_min",       32'h8000_0000, 32'h0000_0001, 1'b0, pack(32'h7FFF_FFFF, 0, 0, 0, 1), 2);
    run_vec("zero_bin",      32'h1234_5678, 32'h1234_5677, 1'b1, pack(32'h0000_0000, 0, 1, 0, 0), 0);
    run_vec("bin_only",      32'h0000_0000, 32'h0000_0000, 1'b1, pack(32'hFFFF_FFFF, 1, 0, 1, 0), 0);
    run_vec("ovf_max",       32'h7FFF_FFFF, 32'hFFFF_FFFF, 1'b0, pack(32'h8000_0000, 1, 0, 1, 1), 0);

    // backpressure: result held, new request waits for the handshake
    send(32'h0000_0100, 32'h0000_0001, 1'b0);
    wait_valid(0, ok);
    if (!ok) fail("bp_wait_valid");
    snap = {bus.bout, bus.zero, bus.neg, bus.ovf, bus.d};
    check("bp_snapshot", 64'(snap), 64'(pack(32'h0000_00FF, 0, 0, 0, 0)));
    bus.a        = 32'h0000_0005;
    bus.b        = 32'h0000_0003;
    bus.bin      = 1'b0;
    bus.in_valid = 1'b1;
    repeat (3) begin
      @(posedge clk);
      #1;
      check("bp_stable", 64'({bus.bout, bus.zero, bus.neg, bus.ovf, bus.d}), 64'(snap));
      check("bp_in_ready", 64'(bus.in_ready), 64'(0));
      check("bp_state", 64'(dbg_state), 64'(DONE));
    end
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1;
    bus.out_ready = 1'b0;
    check("bp_idle_after_ack", 64'(bus.in_ready), 64'(1));
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    check("bp_accepted", 64'(dbg_state), 64'(BUSY));
    dut_res = '1;
    wait_result(0, 0);
    check("bp_second_result", 64'(dut_res), 64'(pack(32'h0000_0002, 0, 0, 0, 0)));

    // reset in the second busy cycle aborts the operation
    send(32'hDEAD_BEEF, 32'h0123_4567, 1'b0);
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    check("abort_out_valid", 64'(bus.out_valid), 64'(0));
    check("abort_d", 64'(bus.d), 64'(0));
    check("abort_flags", 64'({bus.bout, bus.zero, bus.neg, bus.ovf}), 64'(0));
    check("abort_state", 64'(dbg_state), 64'(IDLE));
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (6) begin
      @(posedge clk);
      #1;
      check("abort_no_result", 64'(bus.out_valid), 64'(0));
    end
    run_vec("after_reset", 32'h0000_1000, 32'h0000_0FFF, 1'b0, pack(32'h0000_0001, 0, 0, 0, 0), 0);

    // throughput with in_valid and out_ready held high
    acc_q.delete();
    bus.a         = 32'hCAFE_0000;
    bus.b         = 32'h0000_BABE;
    bus.bin       = 1'b1;
    bus.in_valid  = 1'b1;
    bus.out_ready = 1'b1;
    ok = 0;
    for (int i = 0; i < 100; i++) begin
      @(posedge clk);
      #1;
      if (acc_q.size() >= 3) begin
        ok = 1;
        break;
      end
    end
    bus.in_valid = 1'b0;
    if (!ok) fail("throughput");
    else begin
      check("throughput_gap1", 64'(acc_q[1] - acc_q[0]), 64'(NCH + 2));
      check("throughput_gap2", 64'(acc_q[2] - acc_q[1]), 64'(NCH + 2));
    end
    repeat (NCH + 2) @(posedge clk);
    #1;
    bus.out_ready = 1'b0;

    // random operations with input noise while busy and random backpressure
    for (int n = 0; n < 40; n++) begin
      ra = $urandom;
      case ($urandom_range(0, 3))
        0: rb = ra;
        1: rb = ra + 32'($urandom_range(0, 2));
        2: rb = {~ra[WIDTH-1], ra[WIDTH-2:0]};
        default: rb = $urandom;
      endcase
      send(ra, rb, 1'($urandom_range(0, 1)));
      wait_result($urandom_range(0, 2), 1);
    end

    repeat (3) @(posedge clk);
    #1;
    check("final_queue_empty", 64'(exp_q.size()), 64'(0));
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
